// File: rtl/motor_move_sequencer.sv
// Queued motor move sequencer: FIFO of {motor, target} commands driving one shared step/dir
// generator. Optional abort support is enabled by defining MOTOR_SEQ_ABORT_EN.
module motor_move_sequencer #(
  parameter int unsigned NUM_MOTORS = 6,
  parameter int unsigned POS_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STEP_DIV   = 50000,
  parameter int unsigned SETTLE     = 100000
) (
  input  logic                  sysclk,
  input  logic                  INIT_n,
  input  logic                  cmd_valid,
  input  logic [3:0]            cmd_motor,
  input  logic [POS_W-1:0]      cmd_value,
`ifdef MOTOR_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  cmd_ready,
  output logic                  cmd_err,
  output logic [NUM_MOTORS-1:0] step,
  output logic [NUM_MOTORS-1:0] dir,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            active_motor,
  input  logic [3:0]            rd_motor,
  output logic [POS_W-1:0]      rd_pos
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StHigh, StLow, StSettle, StDone} state_e;

  state_e state_q, state_d;

  logic                  abort_req;
`ifdef MOTOR_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Command FIFO
  logic [3:0]        fifo_motor_q [FIFO_DEPTH];
  logic [POS_W-1:0]  fifo_value_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q;
  logic              full, empty, cmd_bad, push, pop;

  // Move state
  logic [3:0]        mot_q, act_q, act_d;
  logic [POS_W-1:0]  tgt_q;
  logic [POS_W-1:0]  pos_q [NUM_MOTORS];
  logic [POS_W-1:0]  cur_pos, new_pos, rd_sel, rd_pos_q;
  logic [31:0]       cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              abort_pend_q, abort_pend_d;
  logic              pos_upd;
  logic              err_q;
  logic [NUM_MOTORS-1:0] onehot;

  assign full      = (fifo_cnt_q == FCNT_W'(FIFO_DEPTH));
  assign empty     = (fifo_cnt_q == '0);
  assign cmd_bad   = (32'(cmd_motor) >= NUM_MOTORS) || (cmd_value > POS_W'(999));
  assign push      = cmd_valid && !cmd_bad && !full && !abort_req;
  assign cmd_ready = !full;
  assign cmd_err   = err_q;

  always_ff @(posedge sysclk or negedge INIT_n) begin
    if (!INIT_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      err_q      <= 1'b0;
      mot_q      <= '0;
      tgt_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_motor_q[i] <= '0;
        fifo_value_q[i] <= '0;
      end
    end else begin
      err_q <= cmd_valid && (cmd_bad || full) && !abort_req;
      if (pop) begin
        mot_q <= fifo_motor_q[rd_ptr_q];
        tgt_q <= fifo_value_q[rd_ptr_q];
      end
      if (abort_req) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push) begin
          fifo_motor_q[wr_ptr_q] <= cmd_motor;
          fifo_value_q[wr_ptr_q] <= cmd_value;
          wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
          2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  always_comb begin
    cur_pos = '0;
    rd_sel  = '0;
    for (int i = 0; i < int'(NUM_MOTORS); i++) begin
      if (mot_q == 4'(i))    cur_pos = pos_q[i];
      if (rd_motor == 4'(i)) rd_sel  = pos_q[i];
    end
  end

  assign new_pos = dir_q ? (cur_pos + POS_W'(1)) : (cur_pos - POS_W'(1));

  always_ff @(posedge sysclk or negedge INIT_n) begin
    if (!INIT_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      act_q        <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      act_q        <= act_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    act_d        = act_q;
    abort_pend_d = abort_pend_q;
    pos_upd      = 1'b0;
    pop          = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !abort_req) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        act_d = mot_q;
        cnt_d = '0;
        if (abort_req) begin
          state_d = StIdle;
        end else if (tgt_q == cur_pos) begin
          state_d = StDone;
        end else begin
          dir_d   = (tgt_q > cur_pos);
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (abort_req) abort_pend_d = 1'b1;
        if (cnt_q == STEP_DIV - 1) begin
          cnt_d   = '0;
          state_d = StLow;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StLow: begin
        if (abort_req) abort_pend_d = 1'b1;
        if (cnt_q == STEP_DIV - 1) begin
          cnt_d   = '0;
          pos_upd = 1'b1;
          // An abort lets the current step count, then skips settle and done.
          if (abort_req || abort_pend_q) begin
            abort_pend_d = 1'b0;
            dir_d        = 1'b0;
            state_d      = StIdle;
          end else if (new_pos == tgt_q) begin
            state_d = StSettle;
          end else begin
            state_d = StHigh;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StSettle: begin
        if (abort_req) begin
          dir_d   = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == SETTLE - 1) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        done    = 1'b1;
        dir_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge INIT_n) begin
    if (!INIT_n) begin
      rd_pos_q <= '0;
      for (int i = 0; i < int'(NUM_MOTORS); i++) pos_q[i] <= '0;
    end else begin
      rd_pos_q <= rd_sel;
      for (int i = 0; i < int'(NUM_MOTORS); i++) begin
        if (pos_upd && (mot_q == 4'(i))) pos_q[i] <= new_pos;
      end
    end
  end

  assign onehot       = NUM_MOTORS'(1) << act_q;
  assign step         = (state_q == StHigh) ? onehot : '0;
  assign dir          = (dir_q && (state_q == StHigh || state_q == StLow ||
                                   state_q == StSettle)) ? onehot : '0;
  assign busy         = (state_q != StIdle) || !empty;
  assign active_motor = act_q;
  assign rd_pos       = rd_pos_q;

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Directed bench for motor_move_sequencer with STEP_DIV=2, SETTLE=3.
// Covers the abort port as well when MOTOR_SEQ_ABORT_EN is defined.
module tb_motor_move_sequencer;

  localparam int NM = 6;

  logic          sysclk = 1'b0;
  logic          INIT_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_motor = '0;
  logic [9:0]    cmd_value = '0;
  logic          cmd_ready, cmd_err, busy, done;
  logic [NM-1:0] step, dir;
  logic [3:0]    active_motor;
  logic [3:0]    rd_motor = '0;
  logic [9:0]    rd_pos;
`ifdef MOTOR_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  motor_move_sequencer #(
    .NUM_MOTORS(6), .POS_W(10), .FIFO_DEPTH(4), .STEP_DIV(2), .SETTLE(3)
  ) dut (
    .sysclk(sysclk), .INIT_n(INIT_n),
    .cmd_valid(cmd_valid), .cmd_motor(cmd_motor), .cmd_value(cmd_value),
`ifdef MOTOR_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .step(step), .dir(dir), .busy(busy),
    .done(done), .active_motor(active_motor), .rd_motor(rd_motor), .rd_pos(rd_pos)
  );

  task automatic tick();
    @(negedge sysclk);
  endtask

  // Presents one command for a single edge; returns at the negedge after the sampling edge.
  task automatic send_cmd(input logic [3:0] m, input logic [9:0] v);
    cmd_valid = 1'b1;
    cmd_motor = m;
    cmd_value = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic read_pos(input logic [3:0] m, output logic [9:0] p);
    rd_motor = m;
    tick();
    p = rd_pos;
  endtask

  // Records activity one sample per negedge until busy drops or the budget expires.
  task automatic measure(input int budget, output int pulses, output int highs,
                         output int first_rise, output int done_at, output int dones,
                         output logic [31:0] done_seq, output logic [NM-1:0] step_or,
                         output logic [NM-1:0] dir_or, output bit timeout);
    logic [NM-1:0] prev;
    pulses = 0; highs = 0; first_rise = -1; done_at = -1; dones = 0;
    done_seq = '0; step_or = '0; dir_or = '0; timeout = 1'b1; prev = '0;
    for (int k = 0; k < budget; k++) begin
      if (step != '0) highs++;
      if ((step & ~prev) != '0) begin
        pulses++;
        if (first_rise < 0) first_rise = k;
      end
      prev = step;
      step_or |= step;
      dir_or |= dir;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = k;
        done_seq = {done_seq[27:0], active_motor};
      end
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [9:0] p;
    INIT_n = 1'b0;
    #12;
    checks++; if (step !== '0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++; if (dir !== '0) begin failures++; $display("FAIL reset_dir got=%b exp=0", dir); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++;
    if ({done, cmd_err, active_motor} !== 6'b0) begin
      failures++; $display("FAIL reset_misc got=%b exp=0", {done, cmd_err, active_motor});
    end
    tick();
    INIT_n = 1'b1;
    for (int m = 0; m < 8; m++) begin
      read_pos(4'(m), p);
      checks++;
      if (p !== 10'd0) begin failures++; $display("FAIL reset_rdpos m=%0d got=%0d exp=0", m, p); end
    end
  endtask

  task automatic test_forward();
    int pulses, highs, fr, da, dn; logic [31:0] seq; logic [NM-1:0] so, dor; bit to;
    logic [9:0] p;
    send_cmd(4'd2, 10'd3);
    measure(200, pulses, highs, fr, da, dn, seq, so, dor, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL fwd_timeout got=%0d exp=0", to); end
    checks++; if (fr !== 2) begin failures++; $display("FAIL fwd_first_rise got=%0d exp=2", fr); end
    checks++; if (pulses !== 3) begin failures++; $display("FAIL fwd_pulses got=%0d exp=3", pulses); end
    checks++; if (highs !== 6) begin failures++; $display("FAIL fwd_high_cycles got=%0d exp=6", highs); end
    checks++; if (so !== 6'b000100) begin failures++; $display("FAIL fwd_step_bits got=%b exp=000100", so); end
    checks++; if (dor !== 6'b000100) begin failures++; $display("FAIL fwd_dir got=%b exp=000100", dor); end
    checks++; if (da !== 17) begin failures++; $display("FAIL fwd_done_at got=%0d exp=17", da); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL fwd_dones got=%0d exp=1", dn); end
    read_pos(4'd2, p);
    checks++; if (p !== 10'd3) begin failures++; $display("FAIL fwd_rdpos got=%0d exp=3", p); end
  endtask

  task automatic test_reverse_null();
    int pulses, highs, fr, da, dn; logic [31:0] seq; logic [NM-1:0] so, dor; bit to;
    logic [9:0] p;
    send_cmd(4'd2, 10'd1);
    measure(200, pulses, highs, fr, da, dn, seq, so, dor, to);
    checks++; if (pulses !== 2) begin failures++; $display("FAIL rev_pulses got=%0d exp=2", pulses); end
    checks++; if (highs !== 4) begin failures++; $display("FAIL rev_high_cycles got=%0d exp=4", highs); end
    checks++; if (dor !== 6'b0) begin failures++; $display("FAIL rev_dir got=%b exp=0", dor); end
    checks++; if (da !== 13) begin failures++; $display("FAIL rev_done_at got=%0d exp=13", da); end
    read_pos(4'd2, p);
    checks++; if (p !== 10'd1) begin failures++; $display("FAIL rev_rdpos got=%0d exp=1", p); end
    send_cmd(4'd4, 10'd0);
    measure(200, pulses, highs, fr, da, dn, seq, so, dor, to);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL null_pulses got=%0d exp=0", pulses); end
    checks++; if (da !== 2) begin failures++; $display("FAIL null_done_at got=%0d exp=2", da); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL null_dones got=%0d exp=1", dn); end
    checks++; if (seq !== 32'h4) begin failures++; $display("FAIL null_motor got=%h exp=4", seq); end
  endtask

  task automatic test_rejects();
    send_cmd(4'd7, 10'd5);
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL rej_motor_err got=%b exp=1", cmd_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rej_motor_busy got=%b exp=0", busy); end
    tick();
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL rej_err_width got=%b exp=0", cmd_err); end
    send_cmd(4'd1, 10'd1000);
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL rej_value_err got=%b exp=1", cmd_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rej_value_busy got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses, highs, fr, da, dn; logic [31:0] seq; logic [NM-1:0] so, dor; bit to;
    int errs;
    logic ready_after5;
    logic [9:0] p;
    errs = 0;
    ready_after5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_motor = 4'(i);
      cmd_value = 10'd1;
      tick();
      if (cmd_err) errs++;
      if (i == 4) ready_after5 = cmd_ready;
    end
    cmd_valid = 1'b0;
    checks++; if (ready_after5 !== 1'b0) begin failures++; $display("FAIL q_ready_full got=%b exp=0", ready_after5); end
    checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL q_sixth_err got=%b exp=1", cmd_err); end
    checks++; if (errs !== 1) begin failures++; $display("FAIL q_err_count got=%0d exp=1", errs); end
    measure(500, pulses, highs, fr, da, dn, seq, so, dor, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL q_timeout got=%0d exp=0", to); end
    checks++; if (dn !== 5) begin failures++; $display("FAIL q_dones got=%0d exp=5", dn); end
    checks++; if (seq !== 32'h0001234) begin failures++; $display("FAIL q_order got=%h exp=00001234", seq); end
    read_pos(4'd3, p);
    checks++; if (p !== 10'd1) begin failures++; $display("FAIL q_rdpos3 got=%0d exp=1", p); end
    read_pos(4'd5, p);
    checks++; if (p !== 10'd0) begin failures++; $display("FAIL q_rdpos5 got=%0d exp=0", p); end
  endtask

  task automatic test_reset_mid_move();
    logic [9:0] p;
    send_cmd(4'd0, 10'd10);
    for (int k = 0; k < 10; k++) tick();
    checks++; if (step !== 6'b000001) begin failures++; $display("FAIL mid_third_high got=%b exp=000001", step); end
    #2 INIT_n = 1'b0;
    #1;
    checks++; if (step !== '0) begin failures++; $display("FAIL mid_step_drop got=%b exp=0", step); end
    checks++; if (dir !== '0) begin failures++; $display("FAIL mid_dir_drop got=%b exp=0", dir); end
    tick();
    INIT_n = 1'b1;
    read_pos(4'd0, p);
    checks++; if (p !== 10'd0) begin failures++; $display("FAIL mid_rdpos0 got=%0d exp=0", p); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    tick();
    checks++; if (step !== '0) begin failures++; $display("FAIL mid_no_restart got=%b exp=0", step); end
  endtask

`ifdef MOTOR_SEQ_ABORT_EN
  task automatic test_abort();
    int pulses, highs, fr, da, dn; logic [31:0] seq; logic [NM-1:0] so, dor; bit to;
    logic [9:0] p;
    logic [3:0] mots [3];
    mots[0] = 4'd3; mots[1] = 4'd1; mots[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_motor = mots[i];
      cmd_value = (i == 0) ? 10'd5 : 10'd2;
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (step !== 6'b001000) begin failures++; $display("FAIL ab_second_high got=%b exp=001000", step); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    measure(200, pulses, highs, fr, da, dn, seq, so, dor, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ab_timeout got=%0d exp=0", to); end
    checks++; if (dn !== 0) begin failures++; $display("FAIL ab_dones got=%0d exp=0", dn); end
    checks++; if (highs !== 1) begin failures++; $display("FAIL ab_finish_high got=%0d exp=1", highs); end
    read_pos(4'd3, p);
    checks++; if (p !== 10'd2) begin failures++; $display("FAIL ab_rdpos3 got=%0d exp=2", p); end
    read_pos(4'd1, p);
    checks++; if (p !== 10'd0) begin failures++; $display("FAIL ab_rdpos1 got=%0d exp=0", p); end
    for (int k = 0; k < 10; k++) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_reverse_null();
    test_rejects();
    test_back_to_back();
    test_reset_mid_move();
`ifdef MOTOR_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
